// File: rtl/posit_encode_if.sv
// Bus between the posit adjustment stage and the posit encoder: start/done request
// with operand fields in, encoded posit and status out.
interface posit_encode_if #(
   parameter int N  = 32,
   parameter int MW = 64,
   parameter int SW = 10
);
   // start is a one-cycle request taken only while the encoder is idle (busy low);
   // operands are sampled on that edge only. done is a one-cycle pulse marking
   // posit_out valid, and posit_out then holds until the next accepted start.
   logic          start;
   logic          sign_in;
   logic          zero_in;
   logic          nar_in;
   logic [SW-1:0] scale_in;
   logic [MW-1:0] mant_in;
   logic [N-1:0]  posit_out;
   logic          done;
   logic          busy;
   logic [1:0]    state_dbg;

   modport master (
      output start, sign_in, zero_in, nar_in, scale_in, mant_in,
      input  posit_out, done, busy, state_dbg
   );

   modport slave (
      input  start, sign_in, zero_in, nar_in, scale_in, mant_in,
      output posit_out, done, busy, state_dbg
   );
endinterface

// File: rtl/posit_encode.sv
// Posit packer: builds the regime run one bit per cycle in a shift register,
// then rounds (RNE), saturates and applies the sign to form the final posit.
module posit_encode #(
   parameter int N  = 32,
   parameter int ES = 3,
   parameter int MW = 64
) (
   input  logic          clk,
   input  logic          reset,
   posit_encode_if.slave bus
);
   localparam int SW = 10;
   localparam int AW = ES + MW + N - 3;
   localparam int CW = $clog2(N);

   localparam logic [N-1:0] MAXPOS = {1'b0, {(N-1){1'b1}}};
   localparam logic [N-1:0] NAR    = {1'b1, {(N-1){1'b0}}};
   localparam logic [N-1:0] MINPOS = {{(N-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      ROUND = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t        state_q;
   logic [AW-1:0] asm_q;
   logic [CW-1:0] cnt_q;
   logic          fill_q;
   logic          sign_q;
   logic [N-1:0]  posit_q;
   logic          done_q;

   function automatic logic [N-1:0] apply_sign(input logic s, input logic [N-1:0] v);
      return s ? (N'(0) - v) : v;
   endfunction

   // Regime decode of the incoming scale: k = floor(scale / 2^ES), e = low ES bits.
   logic signed [SW-1:0] k_s;
   int                   k_i;
   logic [ES-1:0]        e_in;
   logic [CW-1:0]        run_len;
   logic                 k_neg;

   assign k_s   = $signed(bus.scale_in) >>> ES;
   assign k_i   = int'(k_s);
   assign e_in  = bus.scale_in[ES-1:0];
   assign k_neg = k_s[SW-1];

   always_comb begin
      run_len = '0;
      if (k_neg) run_len = CW'(-k_i);
      else       run_len = CW'(k_i + 1);
   end

   // The hidden bit is implied by normalisation and never packed.
   logic unused_mant_hi;
   assign unused_mant_hi = ^bus.mant_in[MW-1:MW-2];

   logic [N-2:0] body;
   logic         guard;
   logic         sticky;
   logic         inc;
   logic [N-1:0] rounded;

   assign body   = asm_q[AW-1 -: N-1];
   assign guard  = asm_q[AW-N];
   assign sticky = |asm_q[AW-N-1:0];
   assign inc    = guard & (body[0] | sticky);

   // An all-ones body is already maxpos; rounding up must not wrap into NaR.
   always_comb begin
      rounded = {1'b0, body};
      if (!(&body)) rounded = {1'b0, body} + N'(inc);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         asm_q   <= '0;
         cnt_q   <= '0;
         fill_q  <= 1'b0;
         sign_q  <= 1'b0;
         posit_q <= '0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  sign_q <= bus.sign_in;
                  if (bus.nar_in) begin
                     posit_q <= NAR;
                     done_q  <= 1'b1;
                     state_q <= DONE;
                  end else if (bus.zero_in) begin
                     posit_q <= '0;
                     done_q  <= 1'b1;
                     state_q <= DONE;
                  end else if (k_i >= N - 2) begin
                     posit_q <= apply_sign(bus.sign_in, MAXPOS);
                     done_q  <= 1'b1;
                     state_q <= DONE;
                  end else if (k_i <= -(N - 1)) begin
                     posit_q <= apply_sign(bus.sign_in, MINPOS);
                     done_q  <= 1'b1;
                     state_q <= DONE;
                  end else begin
                     // Terminator sits on top; the run shifts in above it.
                     asm_q   <= {k_neg, e_in, bus.mant_in[MW-3:0], {(N-2){1'b0}}};
                     cnt_q   <= run_len;
                     fill_q  <= ~k_neg;
                     state_q <= SHIFT;
                  end
               end
            end
            SHIFT: begin
               asm_q <= {fill_q, asm_q[AW-1:1]};
               cnt_q <= cnt_q - CW'(1);
               if (cnt_q == CW'(1)) state_q <= ROUND;
            end
            ROUND: begin
               posit_q <= apply_sign(sign_q, rounded);
               done_q  <= 1'b1;
               state_q <= DONE;
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.posit_out = posit_q;
   assign bus.done      = done_q;
   assign bus.busy      = (state_q != IDLE);
   assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_posit_encode.sv
// Directed bench for posit_encode: hand-computed posits, latency, specials,
// busy-time start rejection and asynchronous reset mid-operation.
module tb_posit_encode;
   logic clk   = 1'b0;
   logic reset = 1'b0;

   always #5 clk = ~clk;

   posit_encode_if bus ();

   posit_encode #(.N(32), .ES(3), .MW(64)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] exp_q[$];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_idle();
      bus.start    = 1'b0;
      bus.sign_in  = 1'b0;
      bus.zero_in  = 1'b0;
      bus.nar_in   = 1'b0;
      bus.scale_in = '0;
      bus.mant_in  = '0;
   endtask

   // One request; inputs are scrambled after the start edge to show they are not re-read.
   task automatic run_op(input string tag, input logic sg, input logic zr, input logic nr,
                         input logic [9:0] sc, input logic [63:0] mt,
                         input int exp_lat, input logic [31:0] exp_val);
      int          lat;
      logic        got;
      logic [31:0] want;
      exp_q.push_back(exp_val);
      @(negedge clk);
      bus.sign_in  = sg;
      bus.zero_in  = zr;
      bus.nar_in   = nr;
      bus.scale_in = sc;
      bus.mant_in  = mt;
      bus.start    = 1'b1;
      lat = 0;
      got = 1'b0;
      while (!got && lat < 64) begin
         @(posedge clk);
         #1;
         lat++;
         if (lat == 1) begin
            bus.start    = 1'b0;
            bus.sign_in  = ~sg;
            bus.scale_in = 10'($urandom_range(0, 1023));
            bus.mant_in  = {32'($urandom), 32'($urandom)};
         end
         if (bus.done) got = 1'b1;
      end
      want = exp_q.pop_front();
      check({tag, "_done"}, 64'(got), 64'(1));
      check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
      check({tag, "_val"}, 64'(bus.posit_out), 64'(want));
      @(posedge clk);
      #1;
      check({tag, "_done_clr"}, 64'(bus.done), 64'(0));
      check({tag, "_idle"}, 64'(bus.busy), 64'(0));
   endtask

   initial begin
      int ndone;
      int first;
      drive_idle();

      // Reset state
      #12;
      check("rst_posit", 64'(bus.posit_out), 64'(0));
      check("rst_done", 64'(bus.done), 64'(0));
      check("rst_busy", 64'(bus.busy), 64'(0));
      check("rst_state", 64'(bus.state_dbg), 64'(0));
      @(negedge clk);
      reset = 1'b1;

      // Basic regimes and sign
      run_op("one",      1'b0, 1'b0, 1'b0, 10'd0,   64'h4000000000000000, 3, 32'h40000000);
      run_op("half",     1'b0, 1'b0, 1'b0, 10'h3FF, 64'h4000000000000000, 3, 32'h3C000000);
      run_op("neg_one",  1'b1, 1'b0, 1'b0, 10'd0,   64'h4000000000000000, 3, 32'hC0000000);
      run_op("k2_e1",    1'b0, 1'b0, 1'b0, 10'd17,  64'h6000000000000000, 5, 32'h71800000);

      // Round to nearest even
      run_op("rne_odd",  1'b0, 1'b0, 1'b0, 10'd0, 64'h4000001800000000, 3, 32'h40000002);
      run_op("rne_even", 1'b0, 1'b0, 1'b0, 10'd0, 64'h4000000800000000, 3, 32'h40000000);
      run_op("rne_stk",  1'b0, 1'b0, 1'b0, 10'd0, 64'h4000000800000001, 3, 32'h40000001);
      run_op("rne_low",  1'b0, 1'b0, 1'b0, 10'd0, 64'h4000000400000000, 3, 32'h40000000);
      run_op("rne_neg",  1'b1, 1'b0, 1'b0, 10'd0, 64'h4000001800000000, 3, 32'hBFFFFFFE);

      // Saturation and specials
      run_op("maxpos",   1'b0, 1'b0, 1'b0, 10'd240, 64'h4000000000000000, 1, 32'h7FFFFFFF);
      run_op("minpos",   1'b0, 1'b0, 1'b0, 10'h300, 64'h4000000000000000, 1, 32'h00000001);
      run_op("neg_max",  1'b1, 1'b0, 1'b0, 10'd240, 64'h4000000000000000, 1, 32'h80000001);
      run_op("neg_min",  1'b1, 1'b0, 1'b0, 10'h300, 64'h4000000000000000, 1, 32'hFFFFFFFF);
      run_op("nar",      1'b0, 1'b1, 1'b1, 10'd0,   64'h4000000000000000, 1, 32'h80000000);
      run_op("zero",     1'b1, 1'b1, 1'b0, 10'd0,   64'h4000000000000000, 1, 32'h00000000);

      // Longest runs at both ends of the regime range
      run_op("k29_e7",   1'b0, 1'b0, 1'b0, 10'd239, 64'h7FFFFFFFFFFFFFFF, 32, 32'h7FFFFFFF);
      run_op("km30",     1'b0, 1'b0, 1'b0, 10'h310, 64'h4000000000000000, 32, 32'h00000001);
      run_op("km30_e4",  1'b0, 1'b0, 1'b0, 10'h314, 64'h4000000000000000, 32, 32'h00000002);

      // k=29 with starts while busy and one coincident with the done cycle
      exp_q.push_back(32'h7FFFFFFE);
      @(negedge clk);
      bus.sign_in  = 1'b0;
      bus.zero_in  = 1'b0;
      bus.nar_in   = 1'b0;
      bus.scale_in = 10'd232;
      bus.mant_in  = 64'h4000000000000000;
      bus.start    = 1'b1;
      ndone = 0;
      first = 0;
      for (int i = 1; i <= 45; i++) begin
         @(posedge clk);
         #1;
         if (bus.done) begin
            ndone++;
            if (first == 0) first = i;
         end
         bus.start  = (i == 4 || i == 9 || i == 32);
         bus.nar_in = bus.start;
      end
      check("busy_ndone", 64'(ndone), 64'(1));
      check("busy_lat", 64'(first), 64'(32));
      check("busy_val", 64'(bus.posit_out), 64'(exp_q.pop_front()));
      check("busy_idle", 64'(bus.busy), 64'(0));
      drive_idle();

      // Asynchronous reset in the middle of the shift phase
      @(negedge clk);
      bus.scale_in = 10'd232;
      bus.mant_in  = 64'h4000000000000000;
      bus.start    = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         @(posedge clk);
         #1;
         bus.start = 1'b0;
      end
      check("mid_busy", 64'(bus.busy), 64'(1));
      check("mid_state", 64'(bus.state_dbg), 64'(1));
      #2;
      reset = 1'b0;
      #1;
      check("arst_state", 64'(bus.state_dbg), 64'(0));
      check("arst_posit", 64'(bus.posit_out), 64'(0));
      check("arst_done", 64'(bus.done), 64'(0));
      check("arst_busy", 64'(bus.busy), 64'(0));
      repeat (3) @(posedge clk);
      #1;
      check("arst_hold", 64'(bus.busy), 64'(0));
      @(negedge clk);
      reset = 1'b1;
      run_op("post_rst", 1'b0, 1'b0, 1'b0, 10'd0, 64'h4000000000000000, 3, 32'h40000000);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
